// File: rtl/tape_symbol_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : tape_symbol_encoder_if
//  Purpose  : Groups the word-input handshake and the video/status outputs
//             of tape_symbol_encoder into one bundle.
//  Signals  : in_data/in_valid/in_ready - word input handshake
//             video/sync_n/frame_start  - pixel stream to DAC and sync pin
//             underflow_cnt/fifo_level  - status
//  Modports : master - packet source / sink side (drives in_data, in_valid)
//             slave  - encoder side
//  Revision : 1.0 - initial release
// ============================================================================
interface tape_symbol_encoder_if #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16
) ();
   logic [DATA_W-1:0]             in_data;
   logic                          in_valid;
   logic                          in_ready;
   logic [7:0]                    video;
   logic                          sync_n;
   logic                          frame_start;
   logic [15:0]                   underflow_cnt;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;

   modport master (
      output in_data, in_valid,
      input  in_ready, video, sync_n, frame_start, underflow_cnt, fifo_level
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, video, sync_n, frame_start, underflow_cnt, fifo_level
   );
endinterface
`default_nettype wire

// File: rtl/tape_symbol_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tape_symbol_encoder
//  Purpose  : Buffers data words in a FIFO, splits them MSB-first into
//             multi-level symbols and emits them as 8-bit pixel levels inside
//             a line/frame raster with sync, preamble and blanking.
//  Ports    : px_clk - pixel clock, all logic on the rising edge
//             rst    - synchronous active-high reset
//             bus    - tape_symbol_encoder_if.slave (word input, video out,
//                      status)
//  Revision : 1.0 - initial release
// ============================================================================
module tape_symbol_encoder #(
   parameter int DATA_W       = 8,
   parameter int BITS_PER_SYM = 2,
   parameter int FIFO_DEPTH   = 16,
   parameter int LINE_PX      = 858,
   parameter int SYNC_PX      = 64,
   parameter int PREAMBLE_PX  = 16,
   parameter int ACTIVE_SYMS  = 720,
   parameter int LINES        = 525,
   parameter int VSYNC_LINES  = 6
) (
   input  logic                   px_clk,
   input  logic                   rst,
   tape_symbol_encoder_if.slave   bus
);

   localparam int SYMS_PER_WORD = DATA_W / BITS_PER_SYM;
   localparam int NUM_LEVELS    = 1 << BITS_PER_SYM;
   localparam int PX_W          = $clog2(LINE_PX + 1);
   localparam int LN_W          = $clog2(LINES + 1);
   localparam int AW            = $clog2(FIFO_DEPTH);
   localparam int SC_W          = $clog2(SYMS_PER_WORD + 1);

   localparam logic [PX_W-1:0] C_LAST_PX     = PX_W'(LINE_PX - 1);
   localparam logic [PX_W-1:0] C_PRE_START   = PX_W'(SYNC_PX);
   localparam logic [PX_W-1:0] C_ACT_START   = PX_W'(SYNC_PX + PREAMBLE_PX);
   localparam logic [PX_W-1:0] C_BLANK_START = PX_W'(SYNC_PX + PREAMBLE_PX + ACTIVE_SYMS);
   localparam logic [LN_W-1:0] C_LAST_LINE   = LN_W'(LINES - 1);
   localparam logic [LN_W-1:0] C_VSYNC_LINES = LN_W'(VSYNC_LINES);
   localparam logic [AW:0]     C_DEPTH       = (AW+1)'(FIFO_DEPTH);
   localparam logic [SC_W-1:0] C_SPW_M1      = SC_W'(SYMS_PER_WORD - 1);
   localparam logic [7:0]      C_PAD_LEVEL   = 8'd128;

   typedef enum logic [2:0] {
      ST_VSYNC    = 3'd0,
      ST_SYNC     = 3'd1,
      ST_PREAMBLE = 3'd2,
      ST_ACTIVE   = 3'd3,
      ST_BLANK    = 3'd4
   } state_t;

   // Segment of a given raster position. The state register always holds the
   // segment of the pixel currently addressed by px_cnt_q/line_cnt_q.
   function automatic state_t seg_of(input logic [PX_W-1:0] px,
                                     input logic [LN_W-1:0] ln);
      if (ln < C_VSYNC_LINES)      return ST_VSYNC;
      else if (px < C_PRE_START)   return ST_SYNC;
      else if (px < C_ACT_START)   return ST_PREAMBLE;
      else if (px < C_BLANK_START) return ST_ACTIVE;
      else                         return ST_BLANK;
   endfunction

   // ------------------------------------------------------------------------
   // Symbol-to-level table, fixed at elaboration
   // ------------------------------------------------------------------------
   logic [7:0] lvl_tab [NUM_LEVELS];

   for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_lvl
      assign lvl_tab[g] = 8'((g * 255) / (NUM_LEVELS - 1));
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [PX_W-1:0]   px_cnt_q,   px_cnt_d;
   logic [LN_W-1:0]   line_cnt_q, line_cnt_d;
   state_t            state_q,    state_d;

   logic [DATA_W-1:0] sh_q,       sh_d;
   logic [SC_W-1:0]   sh_cnt_q,   sh_cnt_d;
   logic [15:0]       und_q,      und_d;

   logic [7:0]        video_q,    video_d;
   logic              sync_n_q,   sync_n_d;
   logic              fstart_q,   fstart_d;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       level_q,  level_d;
   logic              in_ready_q;
   logic              push, pop;
   logic [DATA_W-1:0] head;
   logic [BITS_PER_SYM-1:0] sym;

   assign head = mem_q[rd_ptr_q];
   // in_ready_q is registered !full, so a full FIFO refuses a push even when
   // a pop happens in the same cycle.
   assign push = bus.in_valid && in_ready_q;

   // ------------------------------------------------------------------------
   // Raster counters and segment FSM next state
   // ------------------------------------------------------------------------
   always_comb begin
      px_cnt_d   = px_cnt_q + 1'b1;
      line_cnt_d = line_cnt_q;
      if (px_cnt_q == C_LAST_PX) begin
         px_cnt_d   = '0;
         line_cnt_d = (line_cnt_q == C_LAST_LINE) ? '0 : line_cnt_q + 1'b1;
      end
      state_d = seg_of(px_cnt_d, line_cnt_d);
   end

   // ------------------------------------------------------------------------
   // Pixel outputs, symbol shifter and FIFO pop
   // ------------------------------------------------------------------------
   always_comb begin
      video_d  = 8'd0;
      sync_n_d = 1'b1;
      fstart_d = (px_cnt_q == '0) && (line_cnt_q == '0);
      pop      = 1'b0;
      sym      = '0;
      sh_d     = sh_q;
      sh_cnt_d = sh_cnt_q;
      und_d    = und_q;

      case (state_q)
         ST_VSYNC, ST_SYNC: begin
            sync_n_d = 1'b0;
         end
         ST_PREAMBLE: begin
            // First preamble pixel is high; parity relative to its start.
            video_d = (px_cnt_q[0] ^ C_PRE_START[0]) ? 8'd0 : 8'hFF;
         end
         ST_ACTIVE: begin
            if (sh_cnt_q != '0) begin
               sym      = sh_q[DATA_W-1 -: BITS_PER_SYM];
               sh_d     = sh_q << BITS_PER_SYM;
               sh_cnt_d = sh_cnt_q - 1'b1;
               video_d  = lvl_tab[sym];
            end else if (level_q != '0) begin
               // Fetch and use the top symbol of the new word this cycle.
               pop      = 1'b1;
               sym      = head[DATA_W-1 -: BITS_PER_SYM];
               sh_d     = head << BITS_PER_SYM;
               sh_cnt_d = C_SPW_M1;
               video_d  = lvl_tab[sym];
            end else begin
               // Nothing to send: pad and retry on the next active pixel.
               video_d = C_PAD_LEVEL;
               if (und_q != 16'hFFFF) begin
                  und_d = und_q + 16'd1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge px_clk) begin
      if (rst) begin
         px_cnt_q   <= '0;
         line_cnt_q <= '0;
         state_q    <= seg_of('0, '0);
         sh_q       <= '0;
         sh_cnt_q   <= '0;
         und_q      <= '0;
         video_q    <= '0;
         sync_n_q   <= 1'b1;
         fstart_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         px_cnt_q   <= px_cnt_d;
         line_cnt_q <= line_cnt_d;
         state_q    <= state_d;
         sh_q       <= sh_d;
         sh_cnt_q   <= sh_cnt_d;
         und_q      <= und_d;
         video_q    <= video_d;
         sync_n_q   <= sync_n_d;
         fstart_q   <= fstart_d;
         level_q    <= level_d;
         in_ready_q <= (level_d != C_DEPTH);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: the pointers and level define what is valid.
   always_ff @(posedge px_clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= bus.in_data;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.video         = video_q;
   assign bus.sync_n        = sync_n_q;
   assign bus.frame_start   = fstart_q;
   assign bus.underflow_cnt = und_q;
   assign bus.fifo_level    = level_q;

endmodule
`default_nettype wire
